// File: rtl/memory_responder.sv
// Memory responder: word RAM plus CLINT timer block behind a valid/ready port.
// Ports: clk, rst, memory_valid/instr/addr/wdata/wstrb in; memory_rdata/ready, timer_irpt, soft_irpt, access_fault out.
module memory_responder #(
  parameter int          RAM_DEPTH   = 16384,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] CLINT_BASE  = 32'h0200_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          TIME_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        timer_irpt,
  output logic        soft_irpt,
  output logic        access_fault
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) << 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ACC_NEXT = (WAIT_STATES > 0) ? WAIT : RESP;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tirq;
  logic [31:0] presc;
  logic        tick;

  logic [31:0] mem [RAM_DEPTH];

  logic        accept;
  logic [31:0] ram_off;
  logic        in_ram;
  logic        in_clint;
  logic [13:0] off;
  logic        sel_msip;
  logic        sel_cmplo;
  logic        sel_cmphi;
  logic        sel_tlo;
  logic        sel_thi;
  logic        clint_ok;
  logic        ram_ok;
  logic        bad;
  logic        is_wr;
  logic        clint_wr;
  logic        ram_wr;
  logic [AW-1:0] ram_idx;
  logic [31:0] clint_rd;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign accept = !rst && memory_valid &&
                  (state == IDLE || state == RESP);

  assign ram_off  = memory_addr - RAM_BASE;
  assign in_ram   = {1'b0, ram_off} < RAM_BYTES;
  assign in_clint = memory_addr[31:16] == CLINT_BASE[31:16];
  assign off      = memory_addr[15:2];

  assign sel_msip  = off == 14'h0000;
  assign sel_cmplo = off == 14'h1000;
  assign sel_cmphi = off == 14'h1001;
  assign sel_tlo   = off == 14'h2FFE;
  assign sel_thi   = off == 14'h2FFF;

  // Instruction fetches never target the timer registers.
  assign clint_ok = in_clint && !memory_instr &&
                    (sel_msip | sel_cmplo | sel_cmphi |
                     sel_tlo | sel_thi);
  assign ram_ok   = !in_clint && in_ram;
  assign bad      = !(clint_ok || ram_ok);
  assign is_wr    = |memory_wstrb;
  assign clint_wr = accept && is_wr && clint_ok;
  assign ram_wr   = accept && is_wr && ram_ok;
  assign ram_idx  = ram_off[AW+1:2];

  always_comb begin
    clint_rd = '0;
    unique case (1'b1)
      sel_msip:  clint_rd = {31'b0, msip};
      sel_cmplo: clint_rd = mtimecmp[31:0];
      sel_cmphi: clint_rd = mtimecmp[63:32];
      sel_tlo:   clint_rd = mtime[31:0];
      sel_thi:   clint_rd = mtime[63:32];
      default:   clint_rd = '0;
    endcase
  end

  assign tick = presc == 32'(TIME_DIV - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      tirq     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 32'd1;
      tirq  <= mtime >= mtimecmp;
      // A software write to either half replaces that cycle's increment.
      if (clint_wr && sel_tlo)
        mtime <= {mtime[63:32],
                  merge(mtime[31:0], memory_wdata, memory_wstrb)};
      else if (clint_wr && sel_thi)
        mtime <= {merge(mtime[63:32], memory_wdata, memory_wstrb),
                  mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;
      if (clint_wr && sel_cmplo)
        mtimecmp[31:0] <=
          merge(mtimecmp[31:0], memory_wdata, memory_wstrb);
      if (clint_wr && sel_cmphi)
        mtimecmp[63:32] <=
          merge(mtimecmp[63:32], memory_wdata, memory_wstrb);
      if (clint_wr && sel_msip && memory_wstrb[0])
        msip <= memory_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr)
      for (int b = 0; b < 4; b++)
        if (memory_wstrb[b])
          mem[ram_idx][8*b +: 8] <= memory_wdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (memory_valid) state <= ACC_NEXT;
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP: state <= memory_valid ? ACC_NEXT : IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        cnt     <= 4'(WAIT_STATES);
        fault_q <= bad;
        if (is_wr || bad) rdata_q <= '0;
        else if (ram_ok)  rdata_q <= mem[ram_idx];
        else              rdata_q <= clint_rd;
      end
    end
  end

  assign memory_ready = state == RESP;
  assign memory_rdata = memory_ready ? rdata_q : '0;
  assign access_fault = memory_ready && fault_q;
  assign timer_irpt   = tirq;
  assign soft_irpt    = msip;

endmodule
